reg_bank_sequencer: RTL

//  Multi-cycle sequencer that drives the register bank's control ports for one data-processing

---
 rtl/reg_bank_sequencer_if.sv | 47 ++++
 rtl/reg_bank_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/reg_bank_sequencer_if.sv
// Bundle between the instruction decoder / register bank / ALU and the sequencer.
// The sequencer is the slave: it answers the decoder handshake and drives the bank controls.
interface reg_bank_sequencer_if #(parameter int DATA_W = 32);
    logic              instr_valid;
    logic              instr_ready;
    logic [3:0]        instr_cond;
    logic [3:0]        instr_rn;
    logic [3:0]        instr_rm;
    logic [3:0]        instr_rd;
    logic              instr_uses_rm;
    logic              instr_writes_rd;
    logic              instr_set_flags;
    logic [3:0]        rb_read_A_sel;
    logic [3:0]        rb_read_B_sel;
    logic              rb_read_B_en;
    logic [3:0]        rb_write_sel;
    logic              rb_write_en;
    logic [DATA_W-1:0] rb_write_data;
    logic              rb_write_pc_en;
    logic [DATA_W-1:0] rb_write_pc;
    logic              rb_cpsr_en;
    logic [3:0]        rb_cpsr_data;
    logic [DATA_W-1:0] rb_pc;
    logic [3:0]        rb_cpsr;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_flags;
    logic              done;
    logic              branch_taken;

    modport master (
        output instr_valid, instr_cond, instr_rn, instr_rm, instr_rd,
               instr_uses_rm, instr_writes_rd, instr_set_flags,
               rb_pc, rb_cpsr, alu_result, alu_flags,
        input  instr_ready, rb_read_A_sel, rb_read_B_sel, rb_read_B_en,
               rb_write_sel, rb_write_en, rb_write_data, rb_write_pc_en,
               rb_write_pc, rb_cpsr_en, rb_cpsr_data, done, branch_taken
    );

    modport slave (
        input  instr_valid, instr_cond, instr_rn, instr_rm, instr_rd,
               instr_uses_rm, instr_writes_rd, instr_set_flags,
               rb_pc, rb_cpsr, alu_result, alu_flags,
        output instr_ready, rb_read_A_sel, rb_read_B_sel, rb_read_B_en,
               rb_write_sel, rb_write_en, rb_write_data, rb_write_pc_en,
               rb_write_pc, rb_cpsr_en, rb_cpsr_data, done, branch_taken
    );
endinterface

// File: rtl/reg_bank_sequencer.sv
// Four-phase sequencer for one data-processing instruction: read operands, evaluate the
// ARM condition, then write back Rd, CPSR flags and PC in a single write-back cycle.
//
// state | meaning
// IDLE  | waiting for a decoded instruction; instr_ready high unless held
// READ  | operand selects presented to the bank for a full cycle
// EXEC  | selects held; ALU result, flags, PC and condition captured at exit
// WB    | single write-back cycle; enables, done and branch_taken from captured values
module reg_bank_sequencer #(
    parameter int DATA_W  = 32,
    parameter int PC_STEP = 4
) (
    input logic                 clk,
    input logic                 reset,
    input logic                 hold,
    reg_bank_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t            state, state_next;
    logic [3:0]        cond_q, rn_q, rm_q, rd_q;
    logic              uses_rm_q, writes_rd_q, set_flags_q;
    logic [DATA_W-1:0] result_q, pc_q;
    logic [3:0]        flags_q;
    logic              cond_pass_q;
    logic              wr_en;

    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            4'h0:    cond_eval = z;
            4'h1:    cond_eval = !z;
            4'h2:    cond_eval = c;
            4'h3:    cond_eval = !c;
            4'h4:    cond_eval = n;
            4'h5:    cond_eval = !n;
            4'h6:    cond_eval = v;
            4'h7:    cond_eval = !v;
            4'h8:    cond_eval = c && !z;
            4'h9:    cond_eval = !c || z;
            4'hA:    cond_eval = (n == v);
            4'hB:    cond_eval = (n != v);
            4'hC:    cond_eval = !z && (n == v);
            4'hD:    cond_eval = z || (n != v);
            4'hE:    cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cond_q      <= '0;
            rn_q        <= '0;
            rm_q        <= '0;
            rd_q        <= '0;
            uses_rm_q   <= 1'b0;
            writes_rd_q <= 1'b0;
            set_flags_q <= 1'b0;
            result_q    <= '0;
            pc_q        <= '0;
            flags_q     <= '0;
            cond_pass_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && bus.instr_valid && !hold) begin
                cond_q      <= bus.instr_cond;
                rn_q        <= bus.instr_rn;
                rm_q        <= bus.instr_rm;
                rd_q        <= bus.instr_rd;
                uses_rm_q   <= bus.instr_uses_rm;
                writes_rd_q <= bus.instr_writes_rd;
                set_flags_q <= bus.instr_set_flags;
            end
            if (state == EXEC && !hold) begin
                result_q    <= bus.alu_result;
                flags_q     <= bus.alu_flags;
                pc_q        <= bus.rb_pc;
                cond_pass_q <= cond_eval(cond_q, bus.rb_cpsr);
            end
        end
    end

    // Everything is gated by reset so an aborted instruction issues nothing in the reset cycle.
    always_comb begin
        state_next         = state;
        wr_en              = 1'b0;
        bus.instr_ready    = 1'b0;
        bus.rb_read_A_sel  = '0;
        bus.rb_read_B_sel  = '0;
        bus.rb_read_B_en   = 1'b0;
        bus.rb_write_sel   = '0;
        bus.rb_write_en    = 1'b0;
        bus.rb_write_data  = '0;
        bus.rb_write_pc_en = 1'b0;
        bus.rb_write_pc    = '0;
        bus.rb_cpsr_en     = 1'b0;
        bus.rb_cpsr_data   = '0;
        bus.done           = 1'b0;
        bus.branch_taken   = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    bus.instr_ready = !hold;
                    if (bus.instr_valid && !hold) state_next = READ;
                end
                READ, EXEC: begin
                    bus.rb_read_A_sel = rn_q;
                    bus.rb_read_B_sel = rm_q;
                    bus.rb_read_B_en  = uses_rm_q;
                    if (!hold) state_next = (state == READ) ? EXEC : WB;
                end
                WB: begin
                    if (!hold) begin
                        wr_en              = cond_pass_q && writes_rd_q;
                        bus.rb_write_en    = wr_en;
                        bus.rb_write_sel   = rd_q;
                        bus.rb_write_data  = result_q;
                        bus.rb_cpsr_en     = cond_pass_q && set_flags_q;
                        bus.rb_cpsr_data   = flags_q;
                        bus.rb_write_pc_en = !(wr_en && rd_q == 4'd15);
                        bus.rb_write_pc    = pc_q + DATA_W'(PC_STEP);
                        bus.done           = 1'b1;
                        bus.branch_taken   = wr_en && rd_q == 4'd15;
                        state_next         = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end
endmodule
